// File: rtl/console_writer.sv
// Text-console write engine: places CPU-written characters at a hardware cursor in video RAM,
// handles CR/LF/BS/FF, and scrolls the screen by copying rows up and blanking the last one.
module console_writer #(
  parameter int unsigned COLS  = 64,
  parameter int unsigned ROWS  = 32,
  parameter logic [7:0]  BLANK = 8'h20,
  parameter int unsigned AW    = $clog2(COLS * ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          we,
  input  logic [1:0]    addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          busy,
  output logic [AW-1:0] vm_addr,
  output logic          vm_we,
  output logic [7:0]    vm_wdata,
  input  logic [7:0]    vm_rdata
);

  localparam int unsigned XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned YW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [XW-1:0] XMAX     = XW'(COLS - 1);
  localparam logic [YW-1:0] YMAX     = YW'(ROWS - 1);
  localparam logic [AW-1:0] ACOLS    = AW'(COLS);
  localparam logic [AW-1:0] ALAST    = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] LASTROW  = AW'((ROWS - 1) * COLS);

  typedef enum logic [2:0] {StIdle, StPut, StScRd, StScWr, StClear} state_e;

  state_e        state_q;
  logic [XW-1:0] cur_x_q;
  logic [YW-1:0] cur_y_q;
  logic          ovf_q;
  logic [7:0]    wdata_q;

  // Copy cycles forward the read data straight through; everything else is registered.
  assign vm_wdata = (state_q == StScWr) ? vm_rdata : wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cur_x_q <= '0;
      cur_y_q <= '0;
      ovf_q   <= 1'b0;
      wdata_q <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      vm_addr <= '0;
      vm_we   <= 1'b0;
    end else begin
      if (cs && !we) begin
        unique case (addr)
          2'd1: begin
            rdata <= {6'b0, ovf_q, busy};
            ovf_q <= 1'b0;
          end
          2'd2:    rdata <= 8'(cur_x_q);
          2'd3:    rdata <= 8'(cur_y_q);
          default: rdata <= '0;
        endcase
      end

      if (cs && we && addr != 2'd1 && busy) ovf_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (cs && we) begin
            unique case (addr)
              2'd0: begin
                case (wdata)
                  8'h0D: cur_x_q <= '0;
                  8'h0A: begin
                    cur_x_q <= '0;
                    if (cur_y_q != YMAX) begin
                      cur_y_q <= cur_y_q + 1'b1;
                    end else begin
                      state_q <= StScRd;
                      busy    <= 1'b1;
                      vm_we   <= 1'b0;
                      vm_addr <= ACOLS;
                    end
                  end
                  8'h08: begin
                    if (cur_x_q != '0) begin
                      cur_x_q <= cur_x_q - 1'b1;
                    end else if (cur_y_q != '0) begin
                      cur_x_q <= XMAX;
                      cur_y_q <= cur_y_q - 1'b1;
                    end
                  end
                  8'h0C: begin
                    state_q <= StClear;
                    busy    <= 1'b1;
                    vm_we   <= 1'b1;
                    vm_addr <= '0;
                    wdata_q <= BLANK;
                    cur_x_q <= '0;
                    cur_y_q <= '0;
                  end
                  default: begin
                    state_q <= StPut;
                    busy    <= 1'b1;
                    vm_we   <= 1'b1;
                    vm_addr <= AW'(cur_y_q) * ACOLS + AW'(cur_x_q);
                    wdata_q <= wdata;
                  end
                endcase
              end
              2'd2:    cur_x_q <= (32'(wdata) >= COLS) ? XMAX : XW'(wdata);
              2'd3:    cur_y_q <= (32'(wdata) >= ROWS) ? YMAX : YW'(wdata);
              default: ;
            endcase
          end
        end

        StPut: begin
          vm_we <= 1'b0;
          if (cur_x_q != XMAX) begin
            cur_x_q <= cur_x_q + 1'b1;
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            cur_x_q <= '0;
            if (cur_y_q != YMAX) begin
              cur_y_q <= cur_y_q + 1'b1;
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              state_q <= StScRd;
              vm_addr <= ACOLS;
            end
          end
        end

        StScRd: begin
          state_q <= StScWr;
          vm_we   <= 1'b1;
          vm_addr <= vm_addr - ACOLS;
        end

        // vm_addr holds the destination; the next source is one row plus one further on.
        StScWr: begin
          if (vm_addr == LASTROW - 1'b1) begin
            state_q <= StClear;
            vm_addr <= LASTROW;
            wdata_q <= BLANK;
          end else begin
            state_q <= StScRd;
            vm_we   <= 1'b0;
            vm_addr <= vm_addr + ACOLS + 1'b1;
          end
        end

        StClear: begin
          if (vm_addr == ALAST) begin
            state_q <= StIdle;
            vm_we   <= 1'b0;
            busy    <= 1'b0;
          end else begin
            vm_addr <= vm_addr + 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_console_writer.sv
// Bench for console_writer: expected video RAM writes and register reads are queued by the
// stimulus and checked by a monitor whenever the DUT writes memory or returns read data.
module tb_console_writer;

  localparam int COLS = 64;
  localparam int ROWS = 32;
  localparam int NCELL = COLS * ROWS;

  typedef struct packed {
    logic [10:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        busy;
  logic [10:0] vm_addr;
  logic        vm_we;
  logic [7:0]  vm_wdata;
  logic [7:0]  vm_rdata;

  logic [7:0] mem   [NCELL];
  logic [7:0] model [NCELL];
  logic       pre_en = 1'b0;
  int         cyc = 0;

  wr_t        wq[$];
  logic [7:0] rq[$];
  logic       rd_chk = 1'b0;
  int         tests = 0;
  int         fails = 0;

  console_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .vm_addr  (vm_addr),
    .vm_we    (vm_we),
    .vm_wdata (vm_wdata),
    .vm_rdata (vm_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read video RAM; preload puts byte r in every cell of row r.
  always @(posedge clk) begin
    if (pre_en) begin
      for (int a = 0; a < NCELL; a++) mem[a] <= 8'(a / COLS);
    end else if (vm_we) begin
      mem[vm_addr] <= vm_wdata;
    end
    vm_rdata <= mem[vm_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (vm_we) begin
        if (wq.size() == 0) begin
          chk("vm_write_unexpected", {vm_addr, vm_wdata}, 0);
        end else begin
          e = wq.pop_front();
          chk("vm_write", {vm_addr, vm_wdata}, {e.a, e.d});
        end
      end
      if (rd_chk) begin
        if (rq.size() == 0) chk("rdata_unexpected", rdata, 0);
        else chk("rdata", rdata, rq.pop_front());
      end
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp);
    rq.push_back(exp);
    cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    cs = 1'b0;
    rd_chk = 1'b1;
    @(posedge clk); #1;
    rd_chk = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int start, input int exp);
    int n = 0;
    while (busy && n < 10000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, cyc - start, exp);
  endtask

  task automatic push_scroll();
    for (int i = COLS; i < NCELL; i++) begin
      wq.push_back({11'(i - COLS), model[i]});
      model[i - COLS] = model[i];
    end
    for (int a = NCELL - COLS; a < NCELL; a++) begin
      wq.push_back({11'(a), 8'h20});
      model[a] = 8'h20;
    end
  endtask

  initial begin
    int s;
    int e;
    fork
      monitor();
    join_none

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_vm_we", vm_we, 0);
    chk("rst_vm_addr", vm_addr, 0);
    chk("rst_vm_wdata", vm_wdata, 0);
    chk("rst_rdata", rdata, 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(2, 8'd0);
    rd(3, 8'd0);
    rd(1, 8'h00);

    // Plain character at the origin
    wq.push_back({11'd0, 8'h41});
    wr(0, 8'h41);
    s = cyc;
    wait_idle("put_busy_cycles", s, 1);
    rd(2, 8'd1);
    rd(0, 8'd0);

    // Wrap from the last column
    wr(2, 8'd63);
    wr(3, 8'd5);
    wq.push_back({11'd383, 8'h42});
    wr(0, 8'h42);
    s = cyc;
    wait_idle("wrap_busy_cycles", s, 1);
    rd(2, 8'd0);
    rd(3, 8'd6);

    // LF on the last row scrolls; writes during the scroll are dropped
    pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
    for (int a = 0; a < NCELL; a++) model[a] = 8'(a / COLS);
    wr(2, 8'd10);
    wr(3, 8'd31);
    push_scroll();
    wr(0, 8'h0A);
    s = cyc;
    wr(0, 8'h43);
    wr(2, 8'd7);
    rd(1, 8'h03);
    rd(1, 8'h01);
    wait_idle("scroll_busy_cycles", s, 4032);
    e = 0;
    for (int a = 0; a < NCELL; a++)
      if (mem[a] != ((a < NCELL - COLS) ? 8'(a / COLS + 1) : 8'h20)) e++;
    chk("scroll_content_errors", e, 0);
    rd(2, 8'd0);
    rd(3, 8'd31);
    rd(1, 8'h00);

    // Character in the bottom-right cell triggers a scroll after the write
    wr(2, 8'd63);
    model[NCELL - 1] = 8'h45;
    wq.push_back({11'(NCELL - 1), 8'h45});
    push_scroll();
    wr(0, 8'h45);
    s = cyc;
    wait_idle("put_scroll_busy_cycles", s, 4033);
    rd(2, 8'd0);
    rd(3, 8'd31);

    // Form feed clears the whole screen
    for (int a = 0; a < NCELL; a++) begin
      wq.push_back({11'(a), 8'h20});
      model[a] = 8'h20;
    end
    wr(0, 8'h0C);
    s = cyc;
    wait_idle("clear_busy_cycles", s, 2048);
    rd(2, 8'd0);
    rd(3, 8'd0);

    // Cursor-only controls and clamping
    wr(3, 8'd3);
    wr(2, 8'd0);
    wr(0, 8'h08);
    chk("bs_busy", busy, 0);
    rd(2, 8'd63);
    rd(3, 8'd2);
    wr(2, 8'd0);
    wr(3, 8'd0);
    wr(0, 8'h08);
    rd(2, 8'd0);
    rd(3, 8'd0);
    wr(3, 8'd40);
    rd(3, 8'd31);
    wr(2, 8'd200);
    rd(2, 8'd63);
    wr(2, 8'd5);
    wr(0, 8'h0D);
    chk("cr_busy", busy, 0);
    rd(2, 8'd0);

    // Reset in the middle of a scroll
    wr(2, 8'd0);
    wr(3, 8'd31);
    push_scroll();
    wr(0, 8'h0A);
    repeat (10) begin @(posedge clk); #1; end
    wr(0, 8'h44);
    repeat (89) begin @(posedge clk); #1; end
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_vm_we", vm_we, 0);
    chk("abort_busy", busy, 0);
    wq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(1, 8'h00);
    rd(2, 8'd0);
    rd(3, 8'd0);

    repeat (3) begin @(posedge clk); #1; end
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/console_writer.md
Name: console_writer

Overview:
- Memory-mapped text-console engine between the 6502 bus decode and the character video RAM that the character PPU scans.
- The CPU writes character codes to a DATA register. The block places each character at the hardware cursor, advances the cursor, and handles control codes.
- When the cursor runs off the bottom row, it scrolls the screen by copying video RAM up one row and blanking the last row.
- It owns the write side of video RAM. The PPU keeps its independent read view.

Parameters:
- COLS, 64, characters per row.
- ROWS, 32, rows on screen.
- BLANK, 8'h20, fill code used for scroll and clear.
- AW, $clog2(COLS*ROWS) (11 with defaults), video RAM address width.

Ports:
- clk, in, 1: system clock, shared with CPU and PPU.
- rst_n, in, 1: asynchronous active-low reset.
- cs, in, 1: register select from address decode.
- we, in, 1: CPU write strobe. Qualified by cs.
- addr, in, 2: register index. 0=DATA, 1=STATUS, 2=CUR_X, 3=CUR_Y.
- wdata, in, 8: CPU write data.
- rdata, out, 8: register read data, registered.
- busy, out, 1: operation in progress. Mirrors STATUS bit0.
- vm_addr, out, AW: video RAM address, row-major (y*COLS + x).
- vm_we, out, 1: video RAM write enable.
- vm_wdata, out, 8: video RAM write data.
- vm_rdata, in, 8: video RAM read data. Valid the cycle after vm_addr is presented.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Values on reset:
  - cur_x=0, cur_y=0, busy=0, ovf=0.
  - vm_we=0, vm_addr=0, vm_wdata=0, rdata=0.
  - FSM in IDLE.
  - Video RAM contents are untouched by reset.
- Register access: an access is accepted on a rising edge where cs=1.
- Register reads: rdata updates on the edge after the read is accepted.
  - STATUS read returns {6'b0, ovf, busy}.
  - CUR_X and CUR_Y reads return the cursor, zero-extended.
  - DATA read returns 0.
  - Reading STATUS clears ovf on the same edge that updates rdata; the read still returns the old ovf=1.
- Writes while busy:
  - A write to DATA, CUR_X or CUR_Y while busy=1 is dropped and sets ovf.
  - A CUR_X or CUR_Y write while busy=0 loads the value clamped to COLS-1 or ROWS-1.
  - Writes to STATUS are ignored.
- DATA write with busy=0 is decoded as follows:
  - 0x0D (CR): cur_x=0 on the next edge. No memory access. busy stays 0.
  - 0x0A (LF): cur_x=0. If cur_y<ROWS-1, cur_y+1. Otherwise enter SCROLL.
  - 0x08 (BS): if cur_x>0, cur_x-1. Else if cur_y>0, cur_x=COLS-1 and cur_y-1. At (0,0) nothing happens. BS never erases.
  - 0x0C (FF): enter CLEAR with range 0..COLS*ROWS-1, then set cursor to (0,0).
  - Any other code goes to PUT.
- PUT:
  - One cycle with busy=1, vm_we=1, vm_addr=cur_y*COLS+cur_x, vm_wdata=code.
  - Then advance the cursor:
    - If cur_x<COLS-1: cur_x+1, back to IDLE.
    - Else cur_x=0, and if cur_y<ROWS-1: cur_y+1, back to IDLE.
    - Else (last column of last row): enter SCROLL with cur_y held at ROWS-1.
- SCROLL, for i = COLS .. COLS*ROWS-1:
  - SC_RD: vm_addr=i, vm_we=0.
  - SC_WR: vm_addr=i-COLS, vm_wdata=vm_rdata, vm_we=1.
  - After the final SC_WR, go to CLEAR over the last row, addresses (ROWS-1)*COLS .. COLS*ROWS-1.
- CLEAR: one vm_we=1 write of BLANK per cycle, ascending address, then IDLE.
- Busy timing:
  - busy rises on the edge that accepts a busy-causing write.
  - busy falls on the edge after the last vm_we cycle.
  - Durations: PUT = 1 cycle. Scroll = 2*COLS*(ROWS-1)+COLS cycles (4032 with defaults). FF clear = COLS*ROWS cycles (2048).
  - A PUT that triggers a scroll is 1+4032 cycles.
- Sequencing rules:
  - vm_we is never asserted in IDLE.
  - Only one vm_we per cycle.
  - Address arithmetic is unsigned AW-bit and never wraps past COLS*ROWS-1.
- Simultaneous events: a write accepted on the edge where busy falls counts as busy (dropped, ovf set). Software must see busy=0 in STATUS before issuing the write.
- Reset during SCROLL or CLEAR: abort immediately to reset values. Partially copied memory is left as-is.

Test Plan:
- Reset, then write DATA=0x41 -> one cycle vm_we=1, vm_addr=0, vm_wdata=0x41; CUR_X reads 1; busy high for exactly 1 cycle.
- Set cursor (63,5), write 0x42 -> write at addr 383; cursor becomes (0,6); no scroll.
- Preload row r with byte r. Set cursor (10,31), write 0x0A -> busy for 4032 cycles; rows 0..30 hold r+1; row 31 all 0x20; cursor (0,31).
- Write 0x0C -> 2048 consecutive BLANK writes at addrs 0..2047; cursor (0,0).
- During a scroll, write 0x43 and CUR_X=7 -> both dropped, no extra vm_we. STATUS reads 0x03, then 0x01 (ovf cleared by the first read).
- Assert rst_n=0 mid-scroll (cycle 100) -> vm_we=0 and busy=0 at once; cursor (0,0); ovf=0.
- Extra checks: BS at (0,3) -> cursor (63,2); BS at (0,0) -> unchanged; CUR_Y write of 40 -> reads back 31.
